light_display_driver: RTL and testbench
=======================================

Name: light_display_driver

Overview:
- Output-side consumer of the intersection controller interface (state, timeLane1, timeLane2).
- Decodes the controller state code into per-lane red/yellow/green lamp drives.
- Shows both lane countdowns on a 4-digit time-multiplexed 7-segment display.
- Sits between the mode controllers (auto/manual) and the board pins; holds no traffic policy of its own.

Parameters:
- SCAN_DIV, 50000: clocks per digit slot in the display scan (4 slots per frame).
- BLINK_DIV, 25000000: clocks per half-period of the fault-mode yellow flash.
- SEG_ACTIVE_LOW, 1: 1 = segment and digit-enable outputs active-low; 0 = active-high.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- state  input  3  controller state code: GR=3, YR=4, RG=5, RY=6; all other codes = fault.
- timeLane1  input  7  lane 1 remaining seconds; 7'h7F = no countdown.
- timeLane2  input  7  lane 2 remaining seconds; 7'h7F = no countdown.
- lamp1  output  3  lane 1 lamps {red,yellow,green}, active-high.
- lamp2  output  3  lane 2 lamps {red,yellow,green}, active-high.
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- digitEn  output  4  one-hot digit select; bit0 = lane1 tens, bit1 = lane1 ones, bit2 = lane2 tens, bit3 = lane2 ones.

Behaviour:
- Reset (reset low, async):
  - lamp1 = lamp2 = 3'b000; seg and digitEn all inactive.
  - Scan, slot and blink counters cleared; blinkPhase = 0.
  - Latched times = 7'h7F; latched state = fault code 0.
  - First valid outputs appear on the first clk edge after reset release.
- State register: state is sampled into stateQ every clock; lamps are decoded from stateQ (1-cycle latency).
  - GR: lamp1 = 001, lamp2 = 100.
  - YR: lamp1 = 010, lamp2 = 100.
  - RG: lamp1 = 100, lamp2 = 001.
  - RY: lamp1 = 100, lamp2 = 010.
  - Fault (any other code): lamp1 = lamp2 = {0, blinkPhase, 0}; all four digits show dash.
- Blink counter: free-running 0..BLINK_DIV-1; blinkPhase toggles on wrap.
  - The counter is not reset on entering fault, so the flash phase is continuous.
- Scan counter: 0..SCAN_DIV-1; on wrap, slot advances 0→1→2→3→0.
  - digitEn is one-hot on the current slot and registered.
  - Exactly one digit is active at any time; none are active during reset.
- Frame latch: timeLane1 and timeLane2 are captured only when slot wraps 3→0 and the scan counter wraps together. This prevents tearing mid-frame.
  - Input changes within a frame appear at the next frame start; worst-case latency is 4*SCAN_DIV clocks.
- Digit values for each latched time t:
  - t = 7'h7F: both digits show dash (segment g only).
  - 100 ≤ t ≤ 126: saturate to 99.
  - Otherwise tens = t/10 and ones = t%10.
  - Tens digit is blanked when it is 0; ones digit is always shown (t = 0 shows " 0").
- Width rules: divide-by-10 operates on 7 bits; digit results are 4 bits; blank and dash use reserved codes 4'hA (dash) and 4'hF (blank).
- seg is registered in the same cycle as digitEn, so the two always align.
- Reset asserted mid-frame: all outputs go inactive immediately and asynchronously; the scan restarts at slot 0.

Decomposition:
- Shared package traffic_pkg:
  - State codes GR, YR, RG, RY.
  - NO_TIME = 7'h7F.
  - Digit codes DIG_DASH = 4'hA, DIG_BLANK = 4'hF.
  - Lamp encodings LAMP_RED, LAMP_YELLOW, LAMP_GREEN, LAMP_OFF.
- Sub-module seg7_encoder: combinational, 4-bit digit code to 7-bit active-high segments (0-9, dash, blank). The polarity inversion is applied in light_display_driver.

Test Plan (SCAN_DIV=4, BLINK_DIV=8, SEG_ACTIVE_LOW=0):
- Hold reset low with state=GR, timeLane1=25 → lamps 000, seg 0, digitEn 0. Release reset → lamp1=001 and lamp2=100 after 1 clk.
- state=RG, timeLane1=7, timeLane2=42 across a frame boundary → next frame shows slot0 blank, slot1 '7', slot2 '4', slot3 '2'; digitEn cycles 0001, 0010, 0100, 1000 every 4 clks.
- timeLane1=7'h7F → slot0 and slot1 seg = 7'b1000000 (dash). timeLane2=115 → slots 2 and 3 show '9','9'.
- state=0 → lamp1 = lamp2 = 010 for 8 clks then 000 for 8 clks, repeating; all digits dash. Return to YR → lamp1=010 and lamp2=100 steadily, 1 clk later.
- Change timeLane2 from 30 to 29 at slot 1 → digits stay '3','0' until slot wraps 3→0, then show '2','9'; no mixed frame.
- Assert reset during slot 2 → outputs go inactive the same cycle without a clock edge. After release, scanning restarts at digitEn=0001.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared intersection-controller codes plus the time-to-digit split used by the display driver.
package traffic_pkg;

  localparam logic [2:0] ST_GR = 3'd3;
  localparam logic [2:0] ST_YR = 3'd4;
  localparam logic [2:0] ST_RG = 3'd5;
  localparam logic [2:0] ST_RY = 3'd6;

  localparam logic [6:0] NO_TIME = 7'h7F;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } digit_pair_t;

  // Values above 99 saturate; a zero tens digit is blanked so 0..9 show as " n".
  function automatic digit_pair_t time_to_digits(input logic [6:0] t);
    digit_pair_t d;
    logic [6:0]  v;
    logic [3:0]  tens;
    v    = (t >= 7'd100) ? 7'd99 : t;
    tens = 4'(v / 7'd10);
    if (t == NO_TIME) begin
      d.tens = DIG_DASH;
      d.ones = DIG_DASH;
    end else begin
      d.tens = (tens == 4'd0) ? DIG_BLANK : tens;
      d.ones = 4'(v % 7'd10);
    end
    return d;
  endfunction

endpackage

// File: rtl/light_display_driver_if.sv
// Controller-to-display bundle: state/time inputs and lamp/segment outputs.
interface light_display_driver_if;
  logic [2:0] state;
  logic [6:0] timeLane1;
  logic [6:0] timeLane2;
  logic [2:0] lamp1;
  logic [2:0] lamp2;
  logic [6:0] seg;
  logic [3:0] digitEn;

  modport master (
    output state, timeLane1, timeLane2,
    input  lamp1, lamp2, seg, digitEn
  );

  modport slave (
    input  state, timeLane1, timeLane2,
    output lamp1, lamp2, seg, digitEn
  );
endinterface

// File: rtl/seg7_encoder.sv
// Digit code to active-high segments {g,f,e,d,c,b,a}; unknown codes go dark.
module seg7_encoder
  import traffic_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // digit code lookup
  always_comb begin
    o_seg = 7'h00;
    case (i_digit)
      4'd0:      o_seg = 7'h3F;
      4'd1:      o_seg = 7'h06;
      4'd2:      o_seg = 7'h5B;
      4'd3:      o_seg = 7'h4F;
      4'd4:      o_seg = 7'h66;
      4'd5:      o_seg = 7'h6D;
      4'd6:      o_seg = 7'h7D;
      4'd7:      o_seg = 7'h07;
      4'd8:      o_seg = 7'h7F;
      4'd9:      o_seg = 7'h6F;
      DIG_DASH:  o_seg = 7'h40;
      DIG_BLANK: o_seg = 7'h00;
      default:   o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/light_display_driver.sv
// Lamp decode and 4-digit multiplexed countdown display for the intersection controller.
module light_display_driver
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic reset,
  light_display_driver_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] DEN_IDLE = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [2:0]         r_state_q;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [1:0]         r_slot;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [6:0]         r_time1;
  logic [6:0]         r_time2;
  logic [2:0]         r_lamp1;
  logic [2:0]         r_lamp2;
  logic [6:0]         r_seg;
  logic [3:0]         r_digit_en;

  logic        w_scan_wrap;
  logic        w_frame_wrap;
  logic        w_blink_wrap;
  logic        w_blink_phase_nxt;
  logic        w_fault_q;
  logic [2:0]  w_lamp1_nxt;
  logic [2:0]  w_lamp2_nxt;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg_raw;
  logic [6:0]  w_seg_drv;
  logic [3:0]  w_den_drv;
  digit_pair_t w_pair1;
  digit_pair_t w_pair2;

  assign w_scan_wrap       = (r_scan_cnt == SCAN_LAST);
  assign w_frame_wrap      = w_scan_wrap && (r_slot == 2'd3);
  assign w_blink_wrap      = (r_blink_cnt == BLINK_LAST);
  assign w_blink_phase_nxt = r_blink_phase ^ w_blink_wrap;
  assign w_pair1           = time_to_digits(r_time1);
  assign w_pair2           = time_to_digits(r_time2);

  // Lamps are registered from the live state so they equal a decode of stateQ.
  always_comb begin
    w_lamp1_nxt = LAMP_OFF;
    w_lamp2_nxt = LAMP_OFF;
    case (bus.state)
      ST_GR:   begin w_lamp1_nxt = LAMP_GREEN;  w_lamp2_nxt = LAMP_RED;    end
      ST_YR:   begin w_lamp1_nxt = LAMP_YELLOW; w_lamp2_nxt = LAMP_RED;    end
      ST_RG:   begin w_lamp1_nxt = LAMP_RED;    w_lamp2_nxt = LAMP_GREEN;  end
      ST_RY:   begin w_lamp1_nxt = LAMP_RED;    w_lamp2_nxt = LAMP_YELLOW; end
      default: begin
        w_lamp1_nxt = w_blink_phase_nxt ? LAMP_YELLOW : LAMP_OFF;
        w_lamp2_nxt = w_blink_phase_nxt ? LAMP_YELLOW : LAMP_OFF;
      end
    endcase
  end

  // fault flag from the registered state
  always_comb begin
    w_fault_q = 1'b1;
    case (r_state_q)
      ST_GR, ST_YR, ST_RG, ST_RY: w_fault_q = 1'b0;
      default:                    w_fault_q = 1'b1;
    endcase
  end

  // digit code for the current slot
  always_comb begin
    w_digit = DIG_BLANK;
    if (w_fault_q) begin
      w_digit = DIG_DASH;
    end else begin
      case (r_slot)
        2'd0:    w_digit = w_pair1.tens;
        2'd1:    w_digit = w_pair1.ones;
        2'd2:    w_digit = w_pair2.tens;
        2'd3:    w_digit = w_pair2.ones;
        default: w_digit = DIG_BLANK;
      endcase
    end
  end

  seg7_encoder u_seg7 (
    .i_digit (w_digit),
    .o_seg   (w_seg_raw)
  );

  assign w_seg_drv = SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
  assign w_den_drv = SEG_ACTIVE_LOW ? ~(4'b0001 << r_slot) : (4'b0001 << r_slot);

  // Scan/blink counters; times are latched only at a frame boundary to avoid tearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q     <= 3'd0;
      r_scan_cnt    <= '0;
      r_slot        <= 2'd0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_time1       <= NO_TIME;
      r_time2       <= NO_TIME;
    end else begin
      r_state_q     <= bus.state;
      r_scan_cnt    <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      r_slot        <= w_scan_wrap ? r_slot + 2'd1 : r_slot;
      r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
      r_blink_phase <= w_blink_phase_nxt;
      if (w_frame_wrap) begin
        r_time1 <= bus.timeLane1;
        r_time2 <= bus.timeLane2;
      end
    end
  end

  // output registers; seg and digitEn share an edge so they always align
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lamp1    <= LAMP_OFF;
      r_lamp2    <= LAMP_OFF;
      r_seg      <= SEG_IDLE;
      r_digit_en <= DEN_IDLE;
    end else begin
      r_lamp1    <= w_lamp1_nxt;
      r_lamp2    <= w_lamp2_nxt;
      r_seg      <= w_seg_drv;
      r_digit_en <= w_den_drv;
    end
  end

  assign bus.lamp1   = r_lamp1;
  assign bus.lamp2   = r_lamp2;
  assign bus.seg     = r_seg;
  assign bus.digitEn = r_digit_en;

endmodule

// File: tb/tb_light_display_driver.sv
// Randomized and directed bench for light_display_driver against a frame-level reference model.
module tb_light_display_driver;

  localparam int SCAN  = 4;
  localparam int BLINK = 8;
  localparam int FRAME = 4 * SCAN;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   n;
  logic [2:0] prev_state;
  logic [6:0] lat1;
  logic [6:0] lat2;
  logic [6:0] seg_tab [16];

  light_display_driver_if u_if ();

  light_display_driver #(
    .SCAN_DIV       (SCAN),
    .BLINK_DIV      (BLINK),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [5:0] exp_lamps(input logic [2:0] s, input int ph);
    case (s)
      3'd3:    return {3'b001, 3'b100};
      3'd4:    return {3'b010, 3'b100};
      3'd5:    return {3'b100, 3'b001};
      3'd6:    return {3'b100, 3'b010};
      default: return (ph != 0) ? 6'b010010 : 6'b000000;
    endcase
  endfunction

  function automatic logic [3:0] lane_digit(input logic [6:0] t, input bit ones);
    int v;
    if (t == 7'h7F) return 4'hA;
    v = (int'(t) > 99) ? 99 : int'(t);
    if (ones) return 4'(v % 10);
    return (v / 10 == 0) ? 4'hF : 4'(v / 10);
  endfunction

  function automatic bit is_fault(input logic [2:0] s);
    return !(s >= 3'd3 && s <= 3'd6);
  endfunction

  task automatic model_reset();
    n = 0;
    prev_state = 3'd0;
    lat1 = 7'h7F;
    lat2 = 7'h7F;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_lamp1"}, 32'(u_if.lamp1), 32'd0);
    chk({tag, "_lamp2"}, 32'(u_if.lamp2), 32'd0);
    chk({tag, "_seg"}, 32'(u_if.seg), 32'd0);
    chk({tag, "_den"}, 32'(u_if.digitEn), 32'd0);
  endtask

  // One clock: record what the DUT samples, predict outputs, then compare.
  task automatic tick();
    logic [2:0] s_now;
    logic [6:0] t1_now, t2_now;
    logic [5:0] lamps;
    logic [3:0] dig;
    int slot;
    @(posedge clk);
    n++;
    s_now  = u_if.state;
    t1_now = u_if.timeLane1;
    t2_now = u_if.timeLane2;
    lamps  = exp_lamps(s_now, (n / BLINK) % 2);
    slot   = ((n - 1) / SCAN) % 4;
    if (is_fault(prev_state)) dig = 4'hA;
    else if (slot == 0) dig = lane_digit(lat1, 1'b0);
    else if (slot == 1) dig = lane_digit(lat1, 1'b1);
    else if (slot == 2) dig = lane_digit(lat2, 1'b0);
    else dig = lane_digit(lat2, 1'b1);
    if (n % FRAME == 0) begin
      lat1 = t1_now;
      lat2 = t2_now;
    end
    prev_state = s_now;
    #1;
    chk("lamp1", 32'(u_if.lamp1), 32'(lamps[5:3]));
    chk("lamp2", 32'(u_if.lamp2), 32'(lamps[2:0]));
    chk("digitEn", 32'(u_if.digitEn), 32'(4'b0001 << slot));
    chk("seg", 32'(u_if.seg), 32'(seg_tab[dig]));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h40; seg_tab[11] = 7'h00;
    seg_tab[12] = 7'h00; seg_tab[13] = 7'h00; seg_tab[14] = 7'h00; seg_tab[15] = 7'h00;
    model_reset();

    reset = 1'b0;
    u_if.state = 3'd3;
    u_if.timeLane1 = 7'd25;
    u_if.timeLane2 = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");

    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rel_lamp1", 32'(u_if.lamp1), 32'h1);
    chk("rel_lamp2", 32'(u_if.lamp2), 32'h4);

    u_if.state = 3'd5;
    u_if.timeLane1 = 7'd7;
    u_if.timeLane2 = 7'd42;
    run(2 * FRAME + 4);

    u_if.timeLane1 = 7'h7F;
    u_if.timeLane2 = 7'd115;
    run(2 * FRAME);

    u_if.state = 3'd0;
    run(3 * FRAME);

    u_if.state = 3'd4;
    u_if.timeLane2 = 7'd30;
    run(2 * FRAME);
    while (n % FRAME != SCAN + 1) tick();
    u_if.timeLane2 = 7'd29;
    run(2 * FRAME);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) u_if.state = 3'($urandom_range(0, 7));
        else u_if.state = 3'($urandom_range(3, 6));
      end
      if ($urandom_range(0, 9) == 0) u_if.timeLane1 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) u_if.timeLane2 = 7'($urandom_range(0, 127));
      tick();
    end

    while (n % FRAME != 2 * SCAN + 1) tick();
    chk("pre_rst_den", 32'(u_if.digitEn), 32'h4);
    reset = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tick();
    chk("restart_den", 32'(u_if.digitEn), 32'h1);
    run(FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
